ex_div: RTL

//  Parametrised multi-cycle integer divider beside the EX stage: a full-width successor to the single-step DIV0/DIV1 path.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ex_div_step.sv | 22 ++
 rtl/ex_div.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the EX-stage divider: FSM state encoding and request/response bundles.
package cpu_pkg;

    localparam int EXD_XLEN = 32;

    typedef enum logic [2:0] {
        EXD_IDLE,
        EXD_PREP,
        EXD_ITER,
        EXD_FIX,
        EXD_DONE
    } ExdState;

    typedef struct packed {
        logic                sgn;
        logic [EXD_XLEN-1:0] dvd;
        logic [EXD_XLEN-1:0] dvs;
    } ExdReq;

    typedef struct packed {
        logic [EXD_XLEN-1:0] quo;
        logic [EXD_XLEN-1:0] rem;
        logic                dz;
    } ExdRsp;

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when that does not borrow.
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvs,
    input  logic             dvd_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic           borrow;

    assign shifted = {rem_in, dvd_bit};
    assign borrow  = shifted < {1'b0, dvs};
    assign q_bit   = ~borrow;
    // The partial remainder stays below the divisor, so the difference always fits WIDTH bits.
    assign rem_out = borrow ? shifted[WIDTH-1:0] : WIDTH'(shifted - {1'b0, dvs});

endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring integer divider beside the EX stage, STEPS quotient bits per cycle.
// Optional macro J22_EXDIV_DIVZ_EN: early divide-by-zero detection and rsp_dz flag.
module ex_div
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             kill,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic             req_sgn,
    input  logic [WIDTH-1:0] req_dvd,
    input  logic [WIDTH-1:0] req_dvs,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_quo,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_dz
);

    localparam int ITERS = WIDTH / STEPS;
    localparam int CW    = $clog2(ITERS + 1);

    ExdState          state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
    logic             sgn_q, dvd_neg, dvs_neg;
    logic [WIDTH-1:0] rem_c [0:STEPS];
    logic [STEPS-1:0] q_bits;
    logic             req_fire;
    logic             dvs_zero;

    assign req_rdy  = ((state == EXD_IDLE) | ((state == EXD_DONE) & rsp_rdy)) & ~stall;
    assign rsp_vld  = (state == EXD_DONE);
    assign req_fire = req_vld & req_rdy;

`ifdef J22_EXDIV_DIVZ_EN
    logic dz_q;
    assign dvs_zero = (dvs_q == '0);
`else
    assign dvs_zero = 1'b0;
    assign rsp_dz   = 1'b0;
`endif

    // The dividend register doubles as the quotient register: bits leave at the top, quotient bits enter at the bottom.
    assign rem_c[0] = rem_q;
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        ex_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_c[k]),
            .dvs     (dvs_q),
            .dvd_bit (dvd_q[WIDTH-1-k]),
            .rem_out (rem_c[k+1]),
            .q_bit   (q_bits[STEPS-1-k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= EXD_IDLE;
        else if (kill)
            state <= EXD_IDLE;
        else if (!stall)
            state <= state_nxt;
    end

    // A zero divisor under the macro skips ITER but still passes through FIX, giving a two-edge latency.
    always_comb begin
        state_nxt = state;
        case (state)
            EXD_IDLE: if (req_fire) state_nxt = EXD_PREP;
            EXD_PREP: state_nxt = dvs_zero ? EXD_FIX : EXD_ITER;
            EXD_ITER: if (cnt == CW'(1)) state_nxt = EXD_FIX;
            EXD_FIX:  state_nxt = EXD_DONE;
            EXD_DONE: if (rsp_rdy) state_nxt = req_fire ? EXD_PREP : EXD_IDLE;
            default:  state_nxt = EXD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
            rsp_quo <= '0;
            rsp_rem <= '0;
`ifdef J22_EXDIV_DIVZ_EN
            dz_q    <= 1'b0;
            rsp_dz  <= 1'b0;
`endif
        end else if (!kill && !stall) begin
            case (state)
                EXD_IDLE, EXD_DONE: begin
                    if (req_fire) begin
                        sgn_q <= req_sgn;
                        dvd_q <= req_dvd;
                        dvs_q <= req_dvs;
                    end
                end
                EXD_PREP: begin
                    dvd_neg <= sgn_q & dvd_q[WIDTH-1];
                    dvs_neg <= sgn_q & dvs_q[WIDTH-1];
                    rem_q   <= '0;
                    cnt     <= CW'(ITERS);
                    // Keep the raw dividend when the divisor is zero: it becomes the remainder.
                    if (sgn_q && dvd_q[WIDTH-1] && !dvs_zero)
                        dvd_q <= -dvd_q;
                    if (sgn_q && dvs_q[WIDTH-1])
                        dvs_q <= -dvs_q;
`ifdef J22_EXDIV_DIVZ_EN
                    dz_q    <= dvs_zero;
`endif
                end
                EXD_ITER: begin
                    rem_q <= rem_c[STEPS];
                    dvd_q <= WIDTH'({dvd_q, q_bits});
                    cnt   <= cnt - CW'(1);
                end
                EXD_FIX: begin
                    rsp_quo <= (dvd_neg ^ dvs_neg) ? -dvd_q : dvd_q;
                    rsp_rem <= dvd_neg ? -rem_q : rem_q;
`ifdef J22_EXDIV_DIVZ_EN
                    rsp_dz  <= dz_q;
                    if (dz_q) begin
                        rsp_quo <= '1;
                        rsp_rem <= dvd_q;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
